multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
// - Multi-cycle control FSM for the 25-bit, five-field (5x5-bit) instruction datapath.
// - Sequences FETCH/DECODE/EXEC/MEM/WB and drives the enables for PC, IR, ALU, memory and register file.
// - Consumes the instruction-class flags produced by the decoder (control_unit) and the ALU compare flags.
// - Talks to a single shared, variable-latency memory port through a req/ack handshake.
// PARAMETERS
// - MEM_TIMEOUT  15        max wait cycles for mem_ack before ERROR (1..255)
// - HALT_OPCODE  5'b11111  op_code value that stops the sequencer
// - CNT_W        16        width of retired-instruction counter
// PORTS
// - clk          in   1      single clock; all state updates on rising edge
// - rst_n        in   1      synchronous reset, active-low
// - start        in   1      IDLE->FETCH launch; ignored in all other states
// - op_code      in   5      opcode field (part1) of the IR
// - R_type, lw, sw, beq, bne, bgt, jr, jump   in  1 each   decoder class flags
// - alu_zero     in   1      ALU result == 0
// - alu_gt       in   1      ALU operand A > B
// - mem_ack      in   1      memory transfer complete (one-cycle pulse)
// - mem_req      out  1      memory request; held until ack
// - mem_we       out  1      1 = write (sw); valid while mem_req
// - mem_addr_sel out  1      0 = PC (fetch), 1 = ALU result (data)
// - ir_we        out  1      load IR from memory read data
// - alu_en       out  1      ALU operand/result register enable
// - reg_we       out  1      register-file write enable
// - wb_sel       out  1      0 = ALU result, 1 = memory data
// - pc_we        out  1      PC update enable
// - pc_src       out  2      00 PC+1, 01 PC+1+branch_address, 10 j_address, 11 register (jr)
// - busy         out  1      1 in every state except IDLE/HALT/ERROR
// - halted       out  1      1 in HALT
// - err          out  1      1 in ERROR (memory timeout), sticky until reset
// - retired      out  CNT_W  count of completed instructions, saturating
// BEHAVIOUR
// - Reset (rst_n=0 at an edge, any state): state=IDLE, retired=0, timeout cnt=0; all outputs 0 (pc_src 00).
// - Outputs decoded from registered state plus same-cycle mem_ack/flags; in IDLE/HALT/ERROR all enables 0.
// - IDLE: start=1 -> FETCH.
// - FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. On mem_ack: ir_we=1 in the ack cycle -> DECODE.
// - DECODE (1 cycle). Priority: op_code==HALT_OPCODE -> HALT; jump: pc_we, pc_src=10 -> FETCH;
//   jr: pc_we, pc_src=11 -> FETCH; R_type/lw/sw/beq/bne/bgt -> EXEC; no flag set -> NOP:
//   pc_we, pc_src=00 -> FETCH.
// - EXEC (1 cycle): alu_en=1. R_type -> WB; lw or sw -> MEM; branch: pc_we=1,
//   pc_src = taken ? 01 : 00 -> FETCH; taken = beq&alu_zero | bne&~alu_zero | bgt&alu_gt.
//   Priority inside EXEC: R_type > lw > sw > beq > bne > bgt.
// - MEM: mem_req=1, mem_addr_sel=1, mem_we=sw. On ack: lw -> WB; sw -> pc_we, pc_src=00 -> FETCH.
// - WB (1 cycle): reg_we=1, wb_sel=lw, pc_we=1, pc_src=00 -> FETCH.
// - retired += 1 on every instruction completion (any ->FETCH except IDLE->FETCH);
//   saturates at all-ones. HALT itself also counts (DECODE->HALT).
// - Handshake: mem_req rises on FETCH/MEM entry; mem_req, mem_we, mem_addr_sel stable until ack cycle;
//   mem_req low in the cycle after ack. mem_ack while mem_req=0 is ignored.
// - Timeout: counter clears on FETCH/MEM entry, +1 per cycle without ack; reaching MEM_TIMEOUT
//   with no ack -> ERROR. Ack in the same cycle the count reaches limit wins (no error).
// - Class flags sampled only in DECODE/EXEC/MEM-ack/WB; IR is stable there (ir_we only in FETCH).
// - HALT and ERROR are terminal: only rst_n exits. start ignored there.
// - Latency: jump/jr/NOP 2+fetch; branch 3+fetch; R_type 4+fetch; sw 3+fetch+mem; lw 4+fetch+mem.
// STRUCTURE
// - Shared package: state encoding enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR),
//   PC_SRC_* constants (2-bit), default HALT_OPCODE, used also by datapath and bench.
// - One sub-module: mem_timeout_counter (clear/enable/expired), reused by both MEM and FETCH.
// - Rest is monolithic: state register, next-state logic, output decode, retired counter.
// TESTING
// - Reset mid-MEM (lw, ack pending): rst_n=0 one edge -> next cycle state IDLE, mem_req=0, retired=0.
// - R_type, ack after 3 cycles: start -> ir_we on ack, alu_en in EXEC, reg_we=1 wb_sel=0 pc_src=00 in WB; retired=1.
// - beq alu_zero=1 -> pc_we=1 pc_src=01; repeat alu_zero=0 -> pc_src=00; bgt alu_gt=1 -> 01.
// - lw then sw: MEM mem_addr_sel=1, mem_we 0 then 1; lw -> WB wb_sel=1; sw -> no reg_we; retired=2.
// - No ack for MEM_TIMEOUT=15 cycles in FETCH -> err=1, busy=0, mem_req=0; ack on cycle 15 -> DECODE, err=0.
// - op_code=5'b11111 -> halted=1, busy=0, start ignored; CNT_W=2 with 5 NOPs -> retired saturates at 3.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer, its datapath and its bench.
// Contents:
//   seq_state_t          - sequencer state encoding
//   PC_SRC_*             - 2-bit PC source select codes
//   DEFAULT_HALT_OPCODE  - op_code that stops the sequencer
//   TIMEOUT_CNT_W        - width of the memory wait counter (limits up to 255)
//   branch_taken()       - conditional branch resolution from ALU flags
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERROR  = 3'd7
  } seq_state_t;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // PC + 1
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;  // PC + 1 + branch_address
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // j_address
  localparam logic [1:0] PC_SRC_REG    = 2'b11;  // register (jr)

  localparam logic [4:0] DEFAULT_HALT_OPCODE = 5'b11111;

  localparam int TIMEOUT_CNT_W = 8;

  function automatic logic branch_taken(input logic beq, input logic bne, input logic bgt,
                                        input logic alu_zero, input logic alu_gt);
    return (beq & alu_zero) | (bne & ~alu_zero) | (bgt & alu_gt);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_timeout_counter.sv
// Memory wait counter shared by the FETCH and MEM states.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - restart the count from zero (wins over enable)
//   enable      - one more cycle spent waiting without an acknowledge
//   expired     - this waiting cycle is the LIMIT-th one without an acknowledge
module mem_timeout_counter #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != LAST)) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  // Depends only on the registered count, never on clear, so the caller may
  // derive clear from a next-state that itself depends on expired.
  assign expired = enable && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 25-bit five-field instruction datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives PC, IR, ALU, memory and
// register-file enables. Outputs are decoded from the registered state plus
// same-cycle mem_ack and class/ALU flags.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   start                          - launch from IDLE
//   op_code, class flags, alu_*    - decoder and ALU status
//   mem_ack / mem_req, mem_we, mem_addr_sel - shared memory handshake
//   ir_we, alu_en, reg_we, wb_sel, pc_we, pc_src - datapath controls
//   busy, halted, err              - status
//   retired                        - saturating count of completed instructions
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [4:0] HALT_OPCODE = DEFAULT_HALT_OPCODE,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op_code,
  input  logic             R_type,
  input  logic             lw,
  input  logic             sw,
  input  logic             beq,
  input  logic             bne,
  input  logic             bgt,
  input  logic             jr,
  input  logic             jump,
  input  logic             alu_zero,
  input  logic             alu_gt,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             alu_en,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic [CNT_W-1:0] retired_reg;
  logic [CNT_W-1:0] retired_next;
  logic             retire_pulse;
  logic             to_clear;
  logic             to_enable;
  logic             to_expired;

  // Counts waiting cycles of whichever memory access is in flight; any state
  // change restarts it, which covers FETCH/MEM entry including MEM->FETCH.
  assign to_enable = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !mem_ack;
  assign to_clear  = (state_next != state_reg);

  mem_timeout_counter #(
    .LIMIT (MEM_TIMEOUT),
    .CNT_W (TIMEOUT_CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_comb begin
    state_next   = state_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    alu_en       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_SEQ;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end else if (to_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_DECODE: begin
        if (op_code == HALT_OPCODE) begin
          state_next = ST_HALT;
        end else if (jump) begin
          pc_we      = 1'b1;
          pc_src     = PC_SRC_JUMP;
          state_next = ST_FETCH;
        end else if (jr) begin
          pc_we      = 1'b1;
          pc_src     = PC_SRC_REG;
          state_next = ST_FETCH;
        end else if (R_type | lw | sw | beq | bne | bgt) begin
          state_next = ST_EXEC;
        end else begin
          // No class flag: treat as NOP and move on.
          pc_we      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        if (R_type) begin
          state_next = ST_WB;
        end else if (lw | sw) begin
          state_next = ST_MEM;
        end else begin
          pc_we      = 1'b1;
          pc_src     = branch_taken(beq, bne, bgt, alu_zero, alu_gt) ? PC_SRC_BRANCH : PC_SRC_SEQ;
          state_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = sw & ~lw;  // lw outranks sw if both are flagged
        if (mem_ack) begin
          if (lw) begin
            state_next = ST_WB;
          end else begin
            pc_we      = 1'b1;
            state_next = ST_FETCH;
          end
        end else if (to_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        wb_sel     = lw;
        pc_we      = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT:  state_next = ST_HALT;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_HALT) && (state_reg != ST_ERROR);
  assign halted = (state_reg == ST_HALT);
  assign err    = (state_reg == ST_ERROR);

  // An instruction completes on every return to FETCH except the launch from
  // IDLE; the halt instruction completes on DECODE->HALT.
  assign retire_pulse = ((state_next == ST_FETCH) && (state_reg != ST_FETCH) && (state_reg != ST_IDLE))
                     || ((state_reg == ST_DECODE) && (state_next == ST_HALT));

  always_comb begin
    retired_next = retired_reg;
    if (retire_pulse && (retired_reg != {CNT_W{1'b1}})) begin
      retired_next = retired_reg + CNT_W'(1);
    end
  end

  assign retired = retired_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      retired_reg <= retired_next;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer. Inputs change 1ns after the rising
// edge; outputs are sampled 1ns later, well before the next edge.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  logic clk, rst_n, start;
  logic [4:0] op_code;
  logic R_type, lw, sw, beq, bne, bgt, jr, jump, alu_zero, alu_gt, mem_ack;
  logic mem_req, mem_we, mem_addr_sel, ir_we, alu_en, reg_we, wb_sel, pc_we;
  logic [1:0] pc_src;
  logic busy, halted, err;
  logic [15:0] retired;
  logic s_mem_req, s_mem_we, s_mem_addr_sel, s_ir_we, s_alu_en, s_reg_we, s_wb_sel, s_pc_we;
  logic [1:0] s_pc_src;
  logic s_busy, s_halted, s_err;
  logic [1:0] retired_sat;

  int checks = 0;
  int errors = 0;

  multicycle_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
    .R_type(R_type), .lw(lw), .sw(sw), .beq(beq), .bne(bne), .bgt(bgt), .jr(jr), .jump(jump),
    .alu_zero(alu_zero), .alu_gt(alu_gt), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .alu_en(alu_en), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
    .busy(busy), .halted(halted), .err(err), .retired(retired)
  );

  multicycle_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
    .R_type(R_type), .lw(lw), .sw(sw), .beq(beq), .bne(bne), .bgt(bgt), .jr(jr), .jump(jump),
    .alu_zero(alu_zero), .alu_gt(alu_gt), .mem_ack(mem_ack),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr_sel(s_mem_addr_sel), .ir_we(s_ir_we),
    .alu_en(s_alu_en), .reg_we(s_reg_we), .wb_sel(s_wb_sel), .pc_we(s_pc_we), .pc_src(s_pc_src),
    .busy(s_busy), .halted(s_halted), .err(s_err), .retired(retired_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    start = 0; op_code = 5'd0; R_type = 0; lw = 0; sw = 0; beq = 0; bne = 0; bgt = 0;
    jr = 0; jump = 0; alu_zero = 0; alu_gt = 0; mem_ack = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  // Launch from IDLE and acknowledge the first fetch immediately; ends in DECODE.
  task automatic launch_fetch;
    start = 1; tick(); start = 0;
    mem_ack = 1; tick(); mem_ack = 0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
    // Ack while nothing is requested must not move the FSM.
    mem_ack = 1; tick(); mem_ack = 0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_stray_ack: busy %b want 0", busy); end
    // One NOP, then a lw parked in MEM with the ack outstanding.
    launch_fetch(); #1;
    checks++; if (pc_we !== 1'b1 || pc_src !== PC_SRC_SEQ) begin errors++; $display("FAIL nop_decode: pc_we %b pc_src %b want 1 00", pc_we, pc_src); end
    tick();
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL nop_retired: got %0d want 1", retired); end
    lw = 1; mem_ack = 1; tick(); mem_ack = 0;
    tick(); tick(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr_sel !== 1'b1) begin errors++; $display("FAIL lw_in_mem: req %b sel %b want 1 1", mem_req, mem_addr_sel); end
    rst_n = 0; tick(); rst_n = 1; lw = 0; #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || retired !== 16'd0) begin errors++; $display("FAIL reset_mid_mem: req %b busy %b retired %0d want 0 0 0", mem_req, busy, retired); end
    $display("txn reset: mid-MEM lw reset done");
  endtask

  task automatic test_rtype;
    do_reset();
    op_code = 5'd1; R_type = 1;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mem_req !== 1'b1 || ir_we !== 1'b0) begin errors++; $display("FAIL rtype_fetch_wait%0d: req %b ir_we %b want 1 0", i, mem_req, ir_we); end
      tick();
    end
    mem_ack = 1; #1;
    checks++; if (ir_we !== 1'b1 || mem_addr_sel !== 1'b0) begin errors++; $display("FAIL rtype_ack: ir_we %b sel %b want 1 0", ir_we, mem_addr_sel); end
    tick(); mem_ack = 0; #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b1 || pc_we !== 1'b0) begin errors++; $display("FAIL rtype_decode: req %b busy %b pc_we %b want 0 1 0", mem_req, busy, pc_we); end
    tick(); #1;
    checks++; if (alu_en !== 1'b1 || reg_we !== 1'b0) begin errors++; $display("FAIL rtype_exec: alu_en %b reg_we %b want 1 0", alu_en, reg_we); end
    tick(); #1;
    checks++; if (reg_we !== 1'b1 || wb_sel !== 1'b0 || pc_we !== 1'b1 || pc_src !== PC_SRC_SEQ) begin errors++; $display("FAIL rtype_wb: reg_we %b wb_sel %b pc_we %b pc_src %b want 1 0 1 00", reg_we, wb_sel, pc_we, pc_src); end
    tick();
    checks++; if (retired !== 16'd1 || mem_req !== 1'b1) begin errors++; $display("FAIL rtype_retire: retired %0d req %b want 1 1", retired, mem_req); end
    $display("txn rtype: retired=%0d", retired);
  endtask

  task automatic test_branch;
    do_reset();
    start = 1; tick(); start = 0;
    // beq taken
    beq = 1; alu_zero = 1;
    mem_ack = 1; tick(); mem_ack = 0; tick(); #1;
    checks++; if (alu_en !== 1'b1 || pc_we !== 1'b1 || pc_src !== PC_SRC_BRANCH) begin errors++; $display("FAIL beq_taken: alu_en %b pc_we %b pc_src %b want 1 1 01", alu_en, pc_we, pc_src); end
    tick();
    // beq not taken
    alu_zero = 0;
    mem_ack = 1; tick(); mem_ack = 0; tick(); #1;
    checks++; if (pc_we !== 1'b1 || pc_src !== PC_SRC_SEQ) begin errors++; $display("FAIL beq_not_taken: pc_we %b pc_src %b want 1 00", pc_we, pc_src); end
    tick();
    // bgt taken
    beq = 0; bgt = 1; alu_gt = 1;
    mem_ack = 1; tick(); mem_ack = 0; tick(); #1;
    checks++; if (pc_we !== 1'b1 || pc_src !== PC_SRC_BRANCH) begin errors++; $display("FAIL bgt_taken: pc_we %b pc_src %b want 1 01", pc_we, pc_src); end
    tick();
    // bne with zero result is not taken
    bgt = 0; alu_gt = 0; bne = 1; alu_zero = 1;
    mem_ack = 1; tick(); mem_ack = 0; tick(); #1;
    checks++; if (pc_src !== PC_SRC_SEQ) begin errors++; $display("FAIL bne_not_taken: pc_src %b want 00", pc_src); end
    tick();
    checks++; if (retired !== 16'd4) begin errors++; $display("FAIL branch_retired: got %0d want 4", retired); end
    bne = 0; alu_zero = 0;
    $display("txn branch: 4 branches retired=%0d", retired);
  endtask

  task automatic test_lw_sw;
    do_reset();
    start = 1; tick(); start = 0;
    lw = 1;
    mem_ack = 1; tick(); mem_ack = 0; tick(); tick(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr_sel !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lw_mem: req %b sel %b we %b want 1 1 0", mem_req, mem_addr_sel, mem_we); end
    tick(); tick(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr_sel !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lw_mem_hold: req %b sel %b we %b want 1 1 0", mem_req, mem_addr_sel, mem_we); end
    mem_ack = 1; #1;
    checks++; if (pc_we !== 1'b0 || reg_we !== 1'b0) begin errors++; $display("FAIL lw_ack: pc_we %b reg_we %b want 0 0", pc_we, reg_we); end
    tick(); mem_ack = 0; #1;
    checks++; if (reg_we !== 1'b1 || wb_sel !== 1'b1 || mem_req !== 1'b0 || pc_we !== 1'b1) begin errors++; $display("FAIL lw_wb: reg_we %b wb_sel %b req %b pc_we %b want 1 1 0 1", reg_we, wb_sel, mem_req, pc_we); end
    tick();
    lw = 0; sw = 1;
    mem_ack = 1; tick(); mem_ack = 0; tick(); tick(); #1;
    checks++; if (mem_we !== 1'b1 || mem_addr_sel !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL sw_mem: we %b sel %b req %b want 1 1 1", mem_we, mem_addr_sel, mem_req); end
    mem_ack = 1; #1;
    checks++; if (pc_we !== 1'b1 || pc_src !== PC_SRC_SEQ || reg_we !== 1'b0) begin errors++; $display("FAIL sw_ack: pc_we %b pc_src %b reg_we %b want 1 00 0", pc_we, pc_src, reg_we); end
    tick(); mem_ack = 0; #1;
    checks++; if (retired !== 16'd2 || reg_we !== 1'b0) begin errors++; $display("FAIL lw_sw_retired: retired %0d reg_we %b want 2 0", retired, reg_we); end
    sw = 0;
    $display("txn lw_sw: retired=%0d", retired);
  endtask

  task automatic test_jumps;
    do_reset();
    jump = 1; launch_fetch(); #1;
    checks++; if (pc_we !== 1'b1 || pc_src !== PC_SRC_JUMP || alu_en !== 1'b0) begin errors++; $display("FAIL jump_decode: pc_we %b pc_src %b alu_en %b want 1 10 0", pc_we, pc_src, alu_en); end
    tick();
    jump = 0; jr = 1;
    mem_ack = 1; tick(); mem_ack = 0; #1;
    checks++; if (pc_we !== 1'b1 || pc_src !== PC_SRC_REG) begin errors++; $display("FAIL jr_decode: pc_we %b pc_src %b want 1 11", pc_we, pc_src); end
    tick(); jr = 0;
    checks++; if (retired !== 16'd2) begin errors++; $display("FAIL jump_retired: got %0d want 2", retired); end
    $display("txn jumps: jump+jr retired=%0d", retired);
  endtask

  task automatic test_timeout;
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL timeout_cycle15: busy %b err %b want 1 0", busy, err); end
      end
      tick();
    end
    checks++; if (err !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_error: err %b busy %b req %b want 1 0 0", err, busy, mem_req); end
    start = 1; mem_ack = 1; tick(); start = 0; mem_ack = 0;
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL error_sticky: err %b busy %b want 1 0", err, busy); end
    // Ack arriving in the 15th waiting cycle still completes the fetch.
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 14; i++) tick();
    mem_ack = 1; #1;
    checks++; if (ir_we !== 1'b1) begin errors++; $display("FAIL timeout_late_ack: ir_we %b want 1", ir_we); end
    tick(); mem_ack = 0; #1;
    checks++; if (err !== 1'b0 || busy !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_ack_wins: err %b busy %b req %b want 0 1 0", err, busy, mem_req); end
    $display("txn timeout: error and late-ack cases done");
  endtask

  task automatic test_halt;
    do_reset();
    op_code = 5'b11111; jump = 1;  // halt outranks jump
    launch_fetch(); #1;
    checks++; if (pc_we !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL halt_decode: pc_we %b halted %b want 0 0", pc_we, halted); end
    tick();
    checks++; if (halted !== 1'b1 || busy !== 1'b0 || retired !== 16'd1) begin errors++; $display("FAIL halt_state: halted %b busy %b retired %0d want 1 0 1", halted, busy, retired); end
    start = 1; tick(); tick(); start = 0;
    checks++; if (halted !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL halt_start_ignored: halted %b busy %b req %b want 1 0 0", halted, busy, mem_req); end
    op_code = 5'd0; jump = 0;
    $display("txn halt: halted=%b retired=%0d", halted, retired);
  endtask

  task automatic test_back_to_back;
    do_reset();
    start = 1; tick(); start = 0;
    for (int n = 1; n <= 5; n++) begin
      mem_ack = 1; tick(); mem_ack = 0; tick();
      checks++; if (retired_sat !== ((n > 3) ? 2'd3 : 2'(n))) begin errors++; $display("FAIL sat_nop%0d: got %0d want %0d", n, retired_sat, (n > 3) ? 3 : n); end
    end
    checks++; if (retired !== 16'd5) begin errors++; $display("FAIL wide_nop_count: got %0d want 5", retired); end
    $display("txn back_to_back: 5 NOPs retired=%0d sat=%0d", retired, retired_sat);
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_rtype();
    test_branch();
    test_lw_sw();
    test_jumps();
    test_timeout();
    test_halt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
